prio_encoder_irq: RTL and testbench

Parametrised, clocked successor to the 8-to-3 active-low priority encoder. It encodes 2^W active-low request lines. Requests are captured into a pending register in either level or falling-edge mode, with a per-line mask. The highest-priority unmasked request is held as a registered code under a valid/acknowledge handshake. The 74LS148-style status outputs Ys_/Yex_ are kept, so the block can drop in as the interrupt front end of the exam-board designs.

---
 rtl/prio_encoder_irq.sv | 91 +++++++++
 tb/tb_prio_encoder_irq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_irq.sv
// Clocked 2^W-line active-low priority encoder with level/edge pending capture,
// per-line mask, valid/ack handshake on the held code and 74LS148-style status.
module prio_encoder_irq #(
  parameter int W    = 3,
  parameter bit EDGE = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_,
  input  logic              S_,
  input  logic [(1<<W)-1:0] I_,
  input  logic [(1<<W)-1:0] MASK,
  input  logic              ACK,
  output logic [W-1:0]      Y_,
  output logic              VLD,
  output logic              Ys_,
  output logic              Yex_
);

  // state | meaning
  // IDLE  | no code offered; arbitrate effective requests each cycle
  // HOLD  | code latched on Y_ with VLD high until ACK or abort (S_ = 1)
  typedef enum logic {IDLE, HOLD} state_t;

  localparam int N = 1 << W;

  state_t         state;
  logic [N-1:0]   i_q, i_q2, p, p_next, r, clr;
  logic [W-1:0]   sel, y_q;
  logic           any, vld_q, ys_q, yex_q;

  always_comb begin
    r   = p & ~MASK;
    any = |r;
    sel = '0;
    for (int j = 0; j < N; j++) begin
      if (r[j]) sel = j[W-1:0];
    end
    // Retire only the line whose code is being acknowledged; abort leaves P alone.
    clr = '0;
    if (state == HOLD && ACK && !S_) clr[~y_q] = 1'b1;
    // A new falling edge in the same cycle as the clear keeps the line pending.
    if (EDGE) p_next = (p & ~clr) | (i_q2 & ~i_q);
    else      p_next = ~i_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_) begin
      i_q   <= '1;
      i_q2  <= '1;
      p     <= '0;
      y_q   <= '1;
      vld_q <= 1'b0;
      ys_q  <= 1'b1;
      yex_q <= 1'b1;
      state <= IDLE;
    end else begin
      i_q   <= I_;
      i_q2  <= i_q;
      p     <= p_next;
      ys_q  <= S_ | any;
      yex_q <= S_ | ~any;
      case (state)
        IDLE: begin
          if (!S_ && any) begin
            y_q   <= ~sel;
            vld_q <= 1'b1;
            state <= HOLD;
          end else begin
            vld_q <= 1'b0;
          end
        end
        HOLD: begin
          if (S_ || ACK) begin
            vld_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          vld_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign Y_   = y_q;
  assign VLD  = vld_q;
  assign Ys_  = ys_q;
  assign Yex_ = yex_q;

endmodule

// File: tb/tb_prio_encoder_irq.sv
// Bench for prio_encoder_irq: three instances (W=3 level, W=3 edge, W=4 edge)
// checked every cycle against a request-level model, plus directed literal checks.
module tb_prio_encoder_irq;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_v;
  logic        s_v[3], ack_v[3];
  logic [15:0] i_v[3], mask_v[3];
  logic [2:0]  y0, y1;
  logic [3:0]  y2;
  logic        vld[3], ys[3], yex[3];

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  prio_encoder_irq #(.W(3), .EDGE(1'b0)) u_lvl3 (
    .CLK(CLK), .RST_(rst_v), .S_(s_v[0]), .I_(i_v[0][7:0]), .MASK(mask_v[0][7:0]),
    .ACK(ack_v[0]), .Y_(y0), .VLD(vld[0]), .Ys_(ys[0]), .Yex_(yex[0]));

  prio_encoder_irq #(.W(3), .EDGE(1'b1)) u_edg3 (
    .CLK(CLK), .RST_(rst_v), .S_(s_v[1]), .I_(i_v[1][7:0]), .MASK(mask_v[1][7:0]),
    .ACK(ack_v[1]), .Y_(y1), .VLD(vld[1]), .Ys_(ys[1]), .Yex_(yex[1]));

  prio_encoder_irq #(.W(4), .EDGE(1'b1)) u_edg4 (
    .CLK(CLK), .RST_(rst_v), .S_(s_v[2]), .I_(i_v[2]), .MASK(mask_v[2]),
    .ACK(ack_v[2]), .Y_(y2), .VLD(vld[2]), .Ys_(ys[2]), .Yex_(yex[2]));

  function automatic int nw(input int k);
    return (k == 2) ? 4 : 3;
  endfunction

  function automatic bit edg(input int k);
    return k != 0;
  endfunction

  function automatic int highest(input logic [15:0] v, input int n);
    for (int j = n - 1; j >= 0; j--) if (v[j]) return j;
    return -1;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Reference model: input history, pending set, and the index of the offered line.
  logic [15:0] m_iq[3], m_iq2[3], m_p[3];
  bit          m_hold[3], m_ys[3], m_yex[3];
  int          m_y[3];

  always @(posedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      int n, top, clr;
      logic [15:0] nm, np;
      n  = 1 << nw(k);
      nm = 16'((32'd1 << n) - 32'd1);
      if (!rst_v) begin
        m_iq[k] = 16'hFFFF; m_iq2[k] = 16'hFFFF; m_p[k] = '0;
        m_hold[k] = 1'b0; m_y[k] = n - 1; m_ys[k] = 1'b1; m_yex[k] = 1'b1;
      end else begin
        top = highest(m_p[k] & ~mask_v[k] & nm, n);
        m_ys[k]  = s_v[k] || (top >= 0);
        m_yex[k] = s_v[k] || (top < 0);
        clr = -1;
        if (!m_hold[k]) begin
          if (!s_v[k] && top >= 0) begin
            m_hold[k] = 1'b1;
            m_y[k] = (n - 1) ^ top;
          end
        end else if (s_v[k]) begin
          m_hold[k] = 1'b0;
        end else if (ack_v[k]) begin
          m_hold[k] = 1'b0;
          clr = (n - 1) ^ m_y[k];
        end
        if (!edg(k)) begin
          np = ~m_iq[k] & nm;
        end else begin
          np = '0;
          for (int j = 0; j < n; j++)
            np[j] = (m_iq2[k][j] && !m_iq[k][j]) || (m_p[k][j] && j != clr);
        end
        m_p[k]   = np;
        m_iq2[k] = m_iq[k];
        m_iq[k]  = i_v[k] | ~nm;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        logic [15:0] dy;
        dy = (k == 0) ? 16'(y0) : (k == 1) ? 16'(y1) : 16'(y2);
        check($sformatf("cyc_y%0d", k), dy, 16'(m_y[k]));
        check($sformatf("cyc_vld%0d", k), 16'(vld[k]), 16'(m_hold[k]));
        check($sformatf("cyc_ys%0d", k), 16'(ys[k]), 16'(m_ys[k]));
        check($sformatf("cyc_yex%0d", k), 16'(yex[k]), 16'(m_yex[k]));
      end
    end
  end

  initial begin
    rst_v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_v[k] = 1'b1; ack_v[k] = 1'b0; i_v[k] = 16'hFFFF; mask_v[k] = '0;
    end
    tick();
    chk_en = 1'b1;
    tick();
    rst_v = 1'b1;

    // reset / idle
    check("rst_y", 16'(y0), 16'h7);
    check("rst_vld", 16'(vld[0]), 16'h0);
    check("rst_ys", 16'(ys[0]), 16'h1);
    check("rst_yex", 16'(yex[0]), 16'h1);
    s_v[0] = 1'b0;
    tick(); tick();
    check("en_ys", 16'(ys[0]), 16'h0);
    check("en_yex", 16'(yex[0]), 16'h1);

    // level priority: lines 5 and 3
    i_v[0] = 16'hFFD7;
    tick(); tick();
    check("lvl_latency", 16'(vld[0]), 16'h0);
    tick();
    check("lvl_vld", 16'(vld[0]), 16'h1);
    check("lvl_y", 16'(y0), 16'h2);
    check("lvl_yex", 16'(yex[0]), 16'h0);
    check("model_lvl_y", 16'(m_y[0]), 16'h2);
    mask_v[0] = 16'h0020;
    tick();
    check("mask_hold_y", 16'(y0), 16'h2);
    ack_v[0] = 1'b1;
    tick();
    ack_v[0] = 1'b0;
    check("lvl_ack_vld", 16'(vld[0]), 16'h0);
    tick();
    check("lvl_rearb_vld", 16'(vld[0]), 16'h1);
    check("lvl_rearb_y", 16'(y0), 16'h4);
    s_v[0] = 1'b1; i_v[0] = 16'hFFFF; mask_v[0] = '0;
    tick(); tick(); tick();

    // edge latch on line 6
    s_v[1] = 1'b0;
    tick(); tick();
    i_v[1] = 16'hFFBF;
    tick();
    i_v[1] = 16'hFFFF;
    tick(); tick();
    check("edg_vld", 16'(vld[1]), 16'h1);
    check("edg_y", 16'(y1), 16'h1);
    tick(); tick(); tick();
    check("edg_held_y", 16'(y1), 16'h1);
    check("edg_held_vld", 16'(vld[1]), 16'h1);
    ack_v[1] = 1'b1;
    tick();
    ack_v[1] = 1'b0;
    check("edg_ack_vld", 16'(vld[1]), 16'h0);
    tick();
    check("edg_clr_ys", 16'(ys[1]), 16'h0);
    check("edg_clr_vld", 16'(vld[1]), 16'h0);

    // set/clear collision on line 2
    i_v[1] = 16'hFFFB;
    tick();
    i_v[1] = 16'hFFFF;
    tick(); tick();
    check("col_hold_y", 16'(y1), 16'h5);
    i_v[1] = 16'hFFFB;
    tick();
    ack_v[1] = 1'b1; i_v[1] = 16'hFFFF;
    tick();
    ack_v[1] = 1'b0;
    check("col_ack_vld", 16'(vld[1]), 16'h0);
    tick();
    check("col_rearm_vld", 16'(vld[1]), 16'h1);
    check("col_rearm_y", 16'(y1), 16'h5);
    ack_v[1] = 1'b1;
    tick();
    ack_v[1] = 1'b0;
    tick();
    check("col_done_vld", 16'(vld[1]), 16'h0);
    check("col_done_ys", 16'(ys[1]), 16'h0);

    // abort with simultaneous ack, then reset mid-hold
    i_v[1] = 16'hFFDF;
    tick();
    i_v[1] = 16'hFFFF;
    tick(); tick();
    check("abt_hold_y", 16'(y1), 16'h2);
    s_v[1] = 1'b1; ack_v[1] = 1'b1;
    tick();
    s_v[1] = 1'b0; ack_v[1] = 1'b0;
    check("abt_vld", 16'(vld[1]), 16'h0);
    tick();
    check("abt_keep_vld", 16'(vld[1]), 16'h1);
    check("abt_keep_y", 16'(y1), 16'h2);
    rst_v = 1'b0;
    tick();
    rst_v = 1'b1;
    check("mrst_y", 16'(y1), 16'h7);
    check("mrst_vld", 16'(vld[1]), 16'h0);
    check("mrst_ys", 16'(ys[1]), 16'h1);
    check("mrst_yex", 16'(yex[1]), 16'h1);
    tick();
    check("mrst_idle_vld", 16'(vld[1]), 16'h0);
    check("mrst_idle_ys", 16'(ys[1]), 16'h0);
    s_v[1] = 1'b1;

    // W = 4: lines 15 and 0 together
    s_v[2] = 1'b0;
    tick();
    i_v[2] = 16'h7FFE;
    tick();
    i_v[2] = 16'hFFFF;
    tick(); tick();
    check("w4_first_vld", 16'(vld[2]), 16'h1);
    check("w4_first_y", 16'(y2), 16'h0);
    check("model_w4_y", 16'(m_y[2]), 16'h0);
    ack_v[2] = 1'b1;
    tick();
    ack_v[2] = 1'b0;
    tick();
    check("w4_second_vld", 16'(vld[2]), 16'h1);
    check("w4_second_y", 16'(y2), 16'hF);
    ack_v[2] = 1'b1;
    tick();
    ack_v[2] = 1'b0;
    tick();
    check("w4_done_vld", 16'(vld[2]), 16'h0);
    check("w4_done_ys", 16'(ys[2]), 16'h0);

    // randomized traffic on all instances
    for (int c = 0; c < 4000; c++) begin
      rst_v = ($urandom_range(0, 299) != 0);
      for (int k = 0; k < 3; k++) begin
        logic [15:0] iv;
        iv = 16'hFFFF;
        for (int j = 0; j < (1 << nw(k)); j++)
          if ($urandom_range(0, 7) == 0) iv[j] = 1'b0;
        i_v[k] = iv;
        s_v[k] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 15) == 0) mask_v[k] = 16'($urandom);
        ack_v[k] = m_hold[k] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      end
      tick();
    end

    rst_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_v[k] = 1'b1; ack_v[k] = 1'b0; i_v[k] = 16'hFFFF;
    end
    tick(); tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
